// File: rtl/pic_cascade_controller.sv
// 8259A cascade-bus stage: drives CAS with the selected slave ID in master mode
// and detects this PIC's ID on CAS during an INTA sequence in slave mode.
module pic_cascade_controller #(
  parameter int CAS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sp_en_n,
  input  logic       icw1_sngl,
  input  logic [7:0] icw3,
  input  logic       cascade_signal,
  input  logic [2:0] desired_slave,
  input  logic       eoi_to_cascade,
  input  logic       inta_n,
  input  logic [2:0] cas_in,
  input  logic       cascade_flag_ack,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic       sp,
  output logic       cascade_signal_ack,
  output logic       cascade_flag,
  output logic       cas_timeout
);

  localparam int TW = (CAS_TIMEOUT < 1) ? 1 : $clog2(CAS_TIMEOUT + 1);

  typedef enum logic { M_IDLE, M_DRIVE } m_state_t;
  typedef enum logic { S_IDLE, S_SEL } s_state_t;

  m_state_t        m_state;
  s_state_t        s_state;
  logic            cs_prev;
  logic            inta_prev;
  logic            flag_ack_prev;
  logic            inta_cnt;
  logic [TW-1:0]   timer;

  logic cs_rise;
  logic inta_fall;
  logic inta_rise;
  logic flag_ack_chg;
  logic role_change;
  logic slot_mapped;
  logic hold_expired;

  assign cs_rise      = cascade_signal & ~cs_prev;
  assign inta_fall    = inta_prev & ~inta_n;
  assign inta_rise    = ~inta_prev & inta_n;
  assign flag_ack_chg = cascade_flag_ack ^ flag_ack_prev;
  assign role_change  = sp_en_n ^ sp;
  assign slot_mapped  = ~icw1_sngl & icw3[desired_slave];
  assign hold_expired = (timer == TW'(CAS_TIMEOUT));

  // NOTE: every register here is state, so this block uses only non-blocking
  // assignments; blocking ones would let later statements see the new values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state            <= M_IDLE;
      s_state            <= S_IDLE;
      cas_out            <= 3'd0;
      cas_oe             <= 1'b0;
      sp                 <= 1'b1;
      cascade_signal_ack <= 1'b0;
      cascade_flag       <= 1'b0;
      cas_timeout        <= 1'b0;
      cs_prev            <= 1'b0;
      inta_prev          <= 1'b1;
      flag_ack_prev      <= 1'b0;
      inta_cnt           <= 1'b0;
      timer              <= '0;
    end else begin
      sp            <= sp_en_n;
      cs_prev       <= cascade_signal;
      inta_prev     <= inta_n;
      flag_ack_prev <= cascade_flag_ack;
      cas_timeout   <= 1'b0;

      if (role_change) begin
        m_state      <= M_IDLE;
        s_state      <= S_IDLE;
        cas_oe       <= 1'b0;
        cas_out      <= 3'd0;
        cascade_flag <= 1'b0;
        inta_cnt     <= 1'b0;
        timer        <= '0;
      end else if (sp) begin
        s_state      <= S_IDLE;
        cascade_flag <= 1'b0;
        inta_cnt     <= 1'b0;
        if (cs_rise) cascade_signal_ack <= ~cascade_signal_ack;
        case (m_state)
          M_IDLE: begin
            if (cs_rise && slot_mapped) begin
              cas_out <= desired_slave;
              cas_oe  <= 1'b1;
              timer   <= '0;
              m_state <= M_DRIVE;
            end
          end
          M_DRIVE: begin
            // A mapped request outranks a simultaneous EOI or expiry.
            if (cs_rise && slot_mapped) begin
              cas_out <= desired_slave;
              timer   <= '0;
            end else if (eoi_to_cascade || hold_expired) begin
              cas_timeout <= ~eoi_to_cascade;
              cas_oe      <= 1'b0;
              cas_out     <= 3'd0;
              m_state     <= M_IDLE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: m_state <= M_IDLE;
        endcase
      end else begin
        m_state <= M_IDLE;
        cas_oe  <= 1'b0;
        cas_out <= 3'd0;
        timer   <= '0;
        if (icw1_sngl) begin
          s_state      <= S_IDLE;
          cascade_flag <= 1'b0;
          inta_cnt     <= 1'b0;
        end else begin
          if (inta_fall) inta_cnt <= ~inta_cnt;
          case (s_state)
            S_IDLE: begin
              if (inta_cnt && (cas_in == icw3[2:0])) begin
                cascade_flag <= 1'b1;
                s_state      <= S_SEL;
              end
            end
            S_SEL: begin
              // inta_cnt back at 0 means the second INTA pulse is ending.
              if (flag_ack_chg || eoi_to_cascade || (inta_rise && !inta_cnt)) begin
                cascade_flag <= 1'b0;
                s_state      <= S_IDLE;
              end
            end
            default: s_state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule
